// File: rtl/mem_arbiter.sv
// Two-master (instruction / data) arbiter in front of a single AXI-style
// memory port. Exactly one transaction is in flight at a time.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | waiting for a request, arbitration happens here
//   I_AR  | instruction read address phase
//   I_R   | instruction read data phase
//   D_AR  | data read address phase
//   D_R   | data read data phase
//   D_WR  | data write address + write data phases
//   D_B   | data write response phase
module mem_arbiter #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int DATA_FIRST   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    I_RDEN,
    input  logic [C_ADDR_WIDTH-1:0] I_ADDR,
    input  logic                    I_CANCEL,
    output logic [31:0]             I_RDATA,
    output logic                    I_RVALID,
    input  logic                    D_RDEN,
    input  logic                    D_WREN,
    input  logic [C_ADDR_WIDTH-1:0] D_ADDR,
    input  logic [31:0]             D_WDATA,
    input  logic [3:0]              D_WSTRB,
    output logic [31:0]             D_RDATA,
    output logic                    D_RVALID,
    output logic                    D_WDONE,
    output logic [C_ADDR_WIDTH-1:0] M_ARADDR,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [31:0]             M_RDATA,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    output logic [C_ADDR_WIDTH-1:0] M_AWADDR,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [31:0]             M_WDATA,
    output logic [3:0]              M_WSTRB,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic                    M_BVALID,
    output logic                    M_BREADY
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_I_AR = 3'd1;
    localparam logic [2:0] S_I_R  = 3'd2;
    localparam logic [2:0] S_D_AR = 3'd3;
    localparam logic [2:0] S_D_R  = 3'd4;
    localparam logic [2:0] S_D_WR = 3'd5;
    localparam logic [2:0] S_D_B  = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic                    aw_ok_q, w_ok_q;
    logic                    cancel_q;
    logic                    hist_q, last_d_q;
    logic                    armed_q;
    logic                    done_q;
    logic                    i_rvalid_q, d_rvalid_q, d_wdone_q;
    logic [31:0]             i_rdata_q, d_rdata_q;

    logic i_req, d_req, pick_d, can_grant, grant;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic i_deliver;

    assign i_req = I_RDEN;
    assign d_req = D_RDEN | D_WREN;
    // armed_q masks the first cycle after reset release; done_q masks the
    // cycle of a done pulse so a requester that is still holding its level
    // for that one cycle is not granted a duplicate transaction.
    assign can_grant = armed_q & ~done_q;

    assign M_ARVALID = (state_q == S_I_AR) || (state_q == S_D_AR);
    assign M_RREADY  = (state_q == S_I_R)  || (state_q == S_D_R);
    assign M_AWVALID = (state_q == S_D_WR) && !aw_ok_q;
    assign M_WVALID  = (state_q == S_D_WR) && !w_ok_q;
    assign M_BREADY  = (state_q == S_D_B);
    assign M_ARADDR  = addr_q;
    assign M_AWADDR  = addr_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;

    assign ar_hs = M_ARVALID & M_ARREADY;
    assign r_hs  = M_RREADY  & M_RVALID;
    assign aw_hs = M_AWVALID & M_AWREADY;
    assign w_hs  = M_WVALID  & M_WREADY;
    assign b_hs  = M_BREADY  & M_BVALID;

    // A flush seen at any point of the instruction read, including the
    // R handshake cycle itself, swallows the completion pulse.
    assign i_deliver = (state_q == S_I_R) && r_hs && !cancel_q && !I_CANCEL;

    assign I_RDATA  = i_rdata_q;
    assign I_RVALID = i_rvalid_q;
    assign D_RDATA  = d_rdata_q;
    assign D_RVALID = d_rvalid_q;
    assign D_WDONE  = d_wdone_q;

    // Arbitration: on a tie the side not granted last wins; before any
    // grant the DATA_FIRST parameter breaks the tie.
    always_comb begin
        pick_d = d_req;
        if (i_req && d_req) begin
            pick_d = hist_q ? !last_d_q : (DATA_FIRST != 0);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (can_grant && (i_req || d_req)) begin
                    if (!pick_d)      state_d = S_I_AR;
                    else if (D_WREN)  state_d = S_D_WR;
                    else              state_d = S_D_AR;
                end
            end
            S_I_AR:  if (ar_hs) state_d = S_I_R;
            S_I_R:   if (r_hs)  state_d = S_IDLE;
            S_D_AR:  if (ar_hs) state_d = S_D_R;
            S_D_R:   if (r_hs)  state_d = S_IDLE;
            S_D_WR:  if ((aw_ok_q || aw_hs) && (w_ok_q || w_hs)) state_d = S_D_B;
            S_D_B:   if (b_hs)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign grant = (state_q == S_IDLE) && (state_d != S_IDLE);

    // State, latched request fields, handshake bookkeeping and done pulses.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_ok_q    <= 1'b0;
            w_ok_q     <= 1'b0;
            cancel_q   <= 1'b0;
            hist_q     <= 1'b0;
            last_d_q   <= 1'b0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_wdone_q  <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            done_q     <= (state_q != S_IDLE) && (state_d == S_IDLE);
            i_rvalid_q <= i_deliver;
            d_rvalid_q <= (state_q == S_D_R) && r_hs;
            d_wdone_q  <= (state_q == S_D_B) && b_hs;

            if (i_deliver)                    i_rdata_q <= M_RDATA;
            if ((state_q == S_D_R) && r_hs)   d_rdata_q <= M_RDATA;

            if (state_q == S_IDLE) begin
                cancel_q <= 1'b0;
            end else if (((state_q == S_I_AR) || (state_q == S_I_R)) && I_CANCEL) begin
                cancel_q <= 1'b1;
            end

            if (state_q == S_D_WR) begin
                if (aw_hs) aw_ok_q <= 1'b1;
                if (w_hs)  w_ok_q  <= 1'b1;
            end else begin
                aw_ok_q <= 1'b0;
                w_ok_q  <= 1'b0;
            end

            if (grant) begin
                hist_q   <= 1'b1;
                last_d_q <= pick_d;
                addr_q   <= pick_d ? D_ADDR : I_ADDR;
                if (pick_d && D_WREN) begin
                    wdata_q <= D_WDATA;
                    wstrb_q <= D_WSTRB;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small AXI-style slave model.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        I_RDEN = 1'b0, I_CANCEL = 1'b0;
    logic [31:0] I_ADDR = '0;
    logic [31:0] I_RDATA;
    logic        I_RVALID;
    logic        D_RDEN = 1'b0, D_WREN = 1'b0;
    logic [31:0] D_ADDR = '0, D_WDATA = '0;
    logic [3:0]  D_WSTRB = '0;
    logic [31:0] D_RDATA;
    logic        D_RVALID, D_WDONE;
    logic [31:0] M_ARADDR, M_RDATA, M_AWADDR, M_WDATA;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic [3:0]  M_WSTRB;

    always #5 CLK = ~CLK;

    mem_arbiter #(.C_ADDR_WIDTH(32), .DATA_FIRST(1)) dut (
        .CLK(CLK), .RST(RST),
        .I_RDEN(I_RDEN), .I_ADDR(I_ADDR), .I_CANCEL(I_CANCEL),
        .I_RDATA(I_RDATA), .I_RVALID(I_RVALID),
        .D_RDEN(D_RDEN), .D_WREN(D_WREN), .D_ADDR(D_ADDR),
        .D_WDATA(D_WDATA), .D_WSTRB(D_WSTRB),
        .D_RDATA(D_RDATA), .D_RVALID(D_RVALID), .D_WDONE(D_WDONE),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID),
        .M_WREADY(M_WREADY), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY)
    );

    // ---------------- slave model ----------------
    logic [31:0] mem [0:255];
    bit          mem_loaded = 1'b0;
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic        r_pend, b_pend, aw_got, w_got;
    logic [31:0] r_addr, wr_addr, wr_data;
    logic [3:0]  wr_strb;

    assign M_ARREADY = M_ARVALID && (ar_cnt >= ar_delay);
    assign M_RVALID  = r_pend && (r_cnt >= r_delay);
    assign M_RDATA   = M_RVALID ? mem[r_addr[9:2]] : 32'h0;
    assign M_AWREADY = M_AWVALID && (aw_cnt >= aw_delay);
    assign M_WREADY  = M_WVALID && (w_cnt >= w_delay);
    assign M_BVALID  = b_pend && (b_cnt >= b_delay);

    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h1111_1111;
            mem[4]  <= 32'h00A0_0093;
            mem[8]  <= 32'h3333_3333;
            mem[9]  <= 32'h4444_4444;
            mem[64] <= 32'h2222_2222;
            mem_loaded <= 1'b1;
        end
        if (!RST) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            r_addr <= '0; wr_addr <= '0; wr_data <= '0; wr_strb <= '0;
        end else begin
            ar_cnt <= (M_ARVALID && !M_ARREADY) ? ar_cnt + 1 : 0;
            aw_cnt <= (M_AWVALID && !M_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (M_WVALID && !M_WREADY) ? w_cnt + 1 : 0;
            if (M_ARVALID && M_ARREADY) begin
                r_pend <= 1'b1; r_addr <= M_ARADDR; r_cnt <= 0;
            end else if (r_pend) begin
                if (M_RVALID && M_RREADY) r_pend <= 1'b0;
                else                      r_cnt <= r_cnt + 1;
            end
            if (M_AWVALID && M_AWREADY) begin aw_got <= 1'b1; wr_addr <= M_AWADDR; end
            if (M_WVALID && M_WREADY) begin w_got <= 1'b1; wr_data <= M_WDATA; wr_strb <= M_WSTRB; end
            if (aw_got && w_got) begin
                for (int k = 0; k < 4; k++)
                    if (wr_strb[k]) mem[wr_addr[9:2]][8*k +: 8] <= wr_data[8*k +: 8];
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end else if (b_pend) begin
                if (M_BVALID && M_BREADY) b_pend <= 1'b0;
                else                      b_cnt <= b_cnt + 1;
            end
        end
    end

    // ---------------- monitors ----------------
    int          n_irv = 0, n_wdone = 0, n_ar_hs = 0, n_overlap = 0, n_unstable = 0;
    logic        ar_wait = 1'b0;
    logic [31:0] ar_prev = '0;

    always @(negedge CLK) begin
        if (I_RVALID) n_irv++;
        if (D_WDONE) n_wdone++;
        if (I_RVALID && (D_RVALID || D_WDONE)) n_overlap++;
        if (M_ARVALID && M_ARREADY) n_ar_hs++;
        if (ar_wait && M_ARVALID && (M_ARADDR != ar_prev)) n_unstable++;
        ar_wait = M_ARVALID && !M_ARREADY;
        ar_prev = M_ARADDR;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b0; I_RDEN = 1'b0; I_CANCEL = 1'b0; D_RDEN = 1'b0; D_WREN = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        repeat (2) tick();
    endtask

    // which: 0 = I_RVALID, 1 = D_RVALID, 2 = D_WDONE
    task automatic wait_pulse(input string tag, input int which, input int limit, output int cyc);
        cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            tick();
            if ((which == 0 && I_RVALID) || (which == 1 && D_RVALID) || (which == 2 && D_WDONE)) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, got, seen, w0, hs0, un0;
        int order [3];
        logic [31:0] dat [3];

        // ---- reset state and single zero-wait fetch ----
        do_reset();
        check_val("rst_arvalid", {31'd0, M_ARVALID}, 32'd0);
        check_val("rst_rready",  {31'd0, M_RREADY},  32'd0);
        check_val("rst_awvalid", {31'd0, M_AWVALID}, 32'd0);
        check_val("rst_bready",  {31'd0, M_BREADY},  32'd0);
        check_val("rst_irdata",  I_RDATA,  32'd0);
        check_val("rst_araddr",  M_ARADDR, 32'd0);

        I_RDEN = 1'b1; I_ADDR = 32'h10;
        tick();
        check_val("f_c1_arvalid", {31'd0, M_ARVALID}, 32'd1);
        check_val("f_c1_araddr", M_ARADDR, 32'h10);
        tick();
        check_val("f_c2_r_hs", {30'd0, M_RREADY, M_RVALID}, 32'd3);
        tick();
        check_val("f_c3_irvalid", {31'd0, I_RVALID}, 32'd1);
        check_val("f_c3_irdata", I_RDATA, 32'h00A0_0093);
        I_RDEN = 1'b0;
        tick();
        check_val("f_c4_irvalid", {31'd0, I_RVALID}, 32'd0);
        check_val("f_c4_arvalid", {31'd0, M_ARVALID}, 32'd0);

        // ---- tie after reset: D, then I, then D again; repeated tie -> I first ----
        do_reset();
        I_RDEN = 1'b1; I_ADDR = 32'h0; D_RDEN = 1'b1; D_ADDR = 32'h100;
        got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            tick();
            if (D_RVALID) begin
                order[got] = 1; dat[got] = D_RDATA; got++;
                if (got == 3) D_RDEN = 1'b0;
            end
            if (I_RVALID && got < 3) begin
                order[got] = 0; dat[got] = I_RDATA; got++; I_RDEN = 1'b0;
            end
        end
        check_val("tie_count", got, 3);
        check_val("tie_first_is_d", order[0], 1);
        check_val("tie_second_is_i", order[1], 0);
        check_val("tie_third_is_d", order[2], 1);
        check_val("tie_d_data", dat[0], 32'h2222_2222);
        check_val("tie_i_data", dat[1], 32'h1111_1111);
        I_RDEN = 1'b0; D_RDEN = 1'b0;
        repeat (2) tick();
        I_RDEN = 1'b1; D_RDEN = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 2; c++) begin
            tick();
            if (I_RVALID) begin order[got] = 0; got++; I_RDEN = 1'b0; end
            if (D_RVALID && got < 2) begin order[got] = 1; got++; D_RDEN = 1'b0; end
        end
        check_val("tie2_count", got, 2);
        check_val("tie2_first_is_i", order[0], 0);
        I_RDEN = 1'b0; D_RDEN = 1'b0;
        repeat (2) tick();

        // ---- write with AWREADY two cycles after WREADY ----
        aw_delay = 2; w_delay = 0; b_delay = 0;
        w0 = n_wdone;
        D_WREN = 1'b1; D_ADDR = 32'h200; D_WDATA = 32'hDEAD_BEEF; D_WSTRB = 4'hC;
        tick();
        check_val("wr_c1_valids", {30'd0, M_AWVALID, M_WVALID}, 32'd3);
        check_val("wr_c1_wdata", M_WDATA, 32'hDEAD_BEEF);
        check_val("wr_c1_wstrb", {28'd0, M_WSTRB}, 32'hC);
        tick();
        check_val("wr_c2_valids", {30'd0, M_AWVALID, M_WVALID}, 32'd2);
        check_val("wr_c2_awaddr", M_AWADDR, 32'h200);
        wait_pulse("wr_done", 2, 15, cyc);
        D_WREN = 1'b0;
        repeat (3) tick();
        check_val("wr_done_count", n_wdone - w0, 1);
        check_val("wr_mem_word", mem[128], 32'hDEAD_0000);
        D_RDEN = 1'b1; D_ADDR = 32'h200;
        wait_pulse("wr_readback", 1, 10, cyc);
        D_RDEN = 1'b0;
        check_val("wr_readback_data", D_RDATA, 32'hDEAD_0000);
        repeat (2) tick();

        // ---- flush during I_R with RVALID delayed ----
        aw_delay = 0; r_delay = 3;
        I_RDEN = 1'b1; I_ADDR = 32'h20;
        repeat (2) tick();
        check_val("fl_in_ir", {31'd0, M_RREADY}, 32'd1);
        I_CANCEL = 1'b1; I_RDEN = 1'b0;
        tick();
        I_CANCEL = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (I_RVALID) seen++;
        end
        check_val("fl_no_irvalid", seen, 0);
        check_val("fl_idle", {30'd0, M_ARVALID, M_RREADY}, 32'd0);
        r_delay = 0;
        I_RDEN = 1'b1; I_ADDR = 32'h10;
        wait_pulse("fl_next", 0, 10, cyc);
        I_RDEN = 1'b0;
        check_val("fl_next_lat", cyc, 3);
        check_val("fl_next_data", I_RDATA, 32'h00A0_0093);
        repeat (2) tick();

        // ---- cancel coinciding with the R handshake ----
        I_RDEN = 1'b1; I_ADDR = 32'h20;
        repeat (2) tick();
        I_CANCEL = 1'b1; I_RDEN = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            I_CANCEL = 1'b0;
            if (I_RVALID) seen++;
        end
        check_val("cx_no_irvalid", seen, 0);

        // ---- ARREADY held low for 5 cycles ----
        ar_delay = 5;
        hs0 = n_ar_hs; un0 = n_unstable;
        I_RDEN = 1'b1; I_ADDR = 32'h24;
        wait_pulse("bp", 0, 20, cyc);
        I_RDEN = 1'b0;
        check_val("bp_latency", cyc, 8);
        check_val("bp_data", I_RDATA, 32'h4444_4444);
        repeat (2) tick();
        check_val("bp_single_ar", n_ar_hs - hs0, 1);
        check_val("bp_araddr_stable", n_unstable - un0, 0);
        ar_delay = 0;

        // ---- reset while waiting for the write response ----
        b_delay = 10;
        w0 = n_wdone;
        D_WREN = 1'b1; D_ADDR = 32'h208; D_WDATA = 32'h1234_5678; D_WSTRB = 4'hF;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            tick();
            if (M_BREADY) seen = 1;
        end
        check_val("rw_reached_b", seen, 1);
        RST = 1'b0; D_WREN = 1'b0;
        tick();
        check_val("rw_valids", {27'd0, M_ARVALID, M_AWVALID, M_WVALID, M_BREADY, M_RREADY}, 32'd0);
        check_val("rw_pulses", {29'd0, I_RVALID, D_RVALID, D_WDONE}, 32'd0);
        check_val("rw_awaddr", M_AWADDR, 32'd0);
        check_val("rw_wdata", M_WDATA, 32'd0);
        check_val("rw_wstrb", {28'd0, M_WSTRB}, 32'd0);
        check_val("rw_drdata", D_RDATA, 32'd0);
        check_val("rw_irdata", I_RDATA, 32'd0);
        tick();
        RST = 1'b1; b_delay = 0;
        I_RDEN = 1'b1; I_ADDR = 32'h10;
        tick();
        check_val("rw_first_cycle_ignored", {31'd0, M_ARVALID}, 32'd0);
        tick();
        check_val("rw_fetch_ar", {31'd0, M_ARVALID}, 32'd1);
        wait_pulse("rw_fetch", 0, 10, cyc);
        I_RDEN = 1'b0;
        check_val("rw_fetch_data", I_RDATA, 32'h00A0_0093);
        repeat (3) tick();
        check_val("rw_no_wdone", n_wdone - w0, 0);

        check_val("no_pulse_overlap", n_overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 32: width of every address port.
REQ-002 SHALL have parameter DATA_FIRST, default 1: on a tie with no grant history, 1 = data wins, 0 = instruction wins.
REQ-003 SHALL have CLK  in  1  the single clock; every flop is rising-edge.
REQ-004 SHALL have RST  in  1  reset, synchronous, active-low.
REQ-005 SHALL have I_RDEN  in  1  instruction read request, level, held until I_RVALID.
REQ-006 SHALL have I_ADDR  in  C_ADDR_WIDTH  instruction address, stable while I_RDEN.
REQ-007 SHALL have I_CANCEL  in  1  pipeline flush: discard the outstanding instruction read.
REQ-008 SHALL have I_RDATA  out  32  instruction word, registered.
REQ-009 SHALL have I_RVALID  out  1  one-cycle pulse, I_RDATA valid.
REQ-010 SHALL have D_RDEN / D_WREN  in  1 each  data read / write request, level, held until done.
REQ-011 SHALL have D_ADDR  in  C_ADDR_WIDTH  data address.
REQ-012 SHALL have D_WDATA  in  32  write data; D_WSTRB  in  4  byte strobes.
REQ-013 SHALL have D_RDATA  out  32  registered read data; D_RVALID  out  1  pulse.
REQ-014 SHALL have D_WDONE  out  1  one-cycle pulse, write response received.
REQ-015 SHALL have M_AR bundle: M_ARADDR out C_ADDR_WIDTH, M_ARVALID out 1, M_ARREADY in 1.
REQ-016 SHALL have M_R bundle: M_RDATA in 32, M_RVALID in 1, M_RREADY out 1.
REQ-017 SHALL have M_AW/M_W bundle: M_AWADDR, M_AWVALID, M_AWREADY, M_WDATA, M_WSTRB, M_WVALID, M_WREADY; single beat.
REQ-018 SHALL have M_B bundle: M_BVALID in 1, M_BREADY out 1; response code ignored.

Function
REQ-019 SHALL implement states IDLE, I_AR, I_R, D_AR, D_R, D_WR, D_B; exactly one transaction outstanding.
REQ-020 SHALL sample requests only in IDLE; latch address/data/strobe at grant.
REQ-021 SHALL grant on the edge ending the request cycle: I -> I_AR, D read -> D_AR, D write -> D_WR.
REQ-022 SHALL resolve an I-vs-D tie round-robin: the requester not granted last wins; with no history, DATA_FIRST decides.
REQ-023 SHALL treat D_RDEN and D_WREN both high as a write.
REQ-024 SHALL drive M_ARVALID high throughout I_AR/D_AR; on M_ARREADY, advance to I_R/D_R.
REQ-025 SHALL hold M_RREADY=1 only in I_R/D_R; on M_RVALID, register M_RDATA, pulse I_RVALID/D_RVALID next cycle, return to IDLE.
REQ-026 SHALL in D_WR assert M_AWVALID and M_WVALID together; each drops independently after its READY; enter D_B once both are accepted, including same-cycle acceptance.
REQ-027 SHALL hold M_BREADY=1 only in D_B; on M_BVALID, pulse D_WDONE next cycle, return to IDLE.
REQ-028 SHALL achieve 3-cycle minimum read latency with zero-wait slave: request cycle 0, ARVALID 1, RVALID 2, xRVALID 3.
REQ-029 SHALL keep AXI address/data/strobe outputs stable while VALID is high and not yet accepted.
REQ-030 SHALL on I_CANCEL during I_AR/I_R, finish the AXI read but suppress I_RVALID; cancel in IDLE is ignored.
REQ-031 SHALL, when I_CANCEL coincides with the R handshake, suppress that I_RVALID.
REQ-032 SHALL re-sample requests in the cycle after a done pulse; a requester still asserting then starts a new transaction.
REQ-033 SHALL never present an I_RVALID and a D_RVALID/D_WDONE in the same cycle.

Reset
REQ-034 SHALL, while RST=0 at a clock edge, go to IDLE, clear grant history, drive all VALID/READY/pulse outputs 0, and zero I_RDATA, D_RDATA and all M_ address/data outputs.
REQ-035 SHALL on reset mid-transaction drop all AXI VALIDs next cycle with no done pulse; the slave is reset together with the arbiter.
REQ-036 SHALL ignore all requests in the first cycle after RST rises.

Verification
REQ-037 SHALL verify a single fetch: I_RDEN, I_ADDR=0x10, memory 0x00A00093, zero-wait -> ARADDR=0x10 in cycle 1, I_RVALID with 0x00A00093 in cycle 3.
REQ-038 SHALL verify a tie after reset with DATA_FIRST=1: I read 0x0 and D read 0x100 together -> D served first, I next; a repeated tie then serves I first.
REQ-039 SHALL verify a write: D_WREN, 0x200, 0xDEADBEEF, strobe 0xC, AWREADY 2 cycles after WREADY -> one D_WDONE; the word at 0x200 reads 0xDEAD0000 from a zeroed memory.
REQ-040 SHALL verify a flush: I_CANCEL during I_R with RVALID delayed 3 cycles -> no I_RVALID, IDLE afterwards, the next fetch is served normally.
REQ-041 SHALL verify backpressure: ARREADY low 5 cycles -> ARADDR stable, a single transaction, correct data.
REQ-042 SHALL verify reset mid-write: RST=0 in D_B -> outputs zeroed, no D_WDONE, a fetch after reset completes.
